fp_int_to_double: RTL and testbench

Sequential converter from a 64-bit integer (signed or unsigned) to an IEEE-754 double-precision value, used to generate operands for the FPU add/sub/mul/div datapath. It uses valid/ready handshakes on both sides. An iterative normalizer shifts left by a coarse or single step each cycle, then a round-to-nearest-even stage produces the result. It handles one conversion at a time.

---
 rtl/fp_int_to_double_if.sv | 23 ++
 rtl/fp_int_to_double.sv | 104 ++++++++++
 tb/tb_fp_int_to_double.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_int_to_double_if.sv
// Handshake bundle for the 64-bit integer to IEEE-754 double converter.
// A transfer happens on a rising edge where valid & ready are both high; once
// valid is raised, the sender holds it and its payload stable until that edge.
interface fp_int_to_double_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_inexact;

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_result, out_inexact
  );

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_result, out_inexact
  );
endinterface

// File: rtl/fp_int_to_double.sv
// Iterative int64/uint64 to double converter: coarse/single-step left normalize,
// then round-to-nearest-even. One conversion in flight at a time.
module fp_int_to_double #(
  parameter int COARSE = 8
) (
  input  logic                clk,
  input  logic                rst,
  fp_int_to_double_if.slave   bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [63:0] mag, mag_n;
  logic [10:0] expo, expo_n;
  logic        neg, neg_n;
  logic [63:0] result, result_n;
  logic        inexact, inexact_n;

  logic        neg_in;
  logic [63:0] mag_in;
  logic        round_up;
  logic [52:0] mant_sum;

  // Negating 0x8000...0 wraps back to itself, which read unsigned is exactly 2^63.
  assign neg_in   = bus.in_signed & bus.in_data[63];
  assign mag_in   = neg_in ? (~bus.in_data + 64'd1) : bus.in_data;
  assign round_up = mag[10] & ((|mag[9:0]) | mag[11]);
  assign mant_sum = {1'b0, mag[62:11]} + {52'd0, round_up};

  assign bus.in_ready    = (state == IDLE) & ~rst;
  assign bus.out_valid   = (state == DONE);
  assign bus.out_result  = result;
  assign bus.out_inexact = inexact;
  assign dbg_state       = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mag     <= '0;
      expo    <= '0;
      neg     <= 1'b0;
      result  <= '0;
      inexact <= 1'b0;
    end else begin
      state   <= state_n;
      mag     <= mag_n;
      expo    <= expo_n;
      neg     <= neg_n;
      result  <= result_n;
      inexact <= inexact_n;
    end
  end

  always_comb begin
    state_n   = state;
    mag_n     = mag;
    expo_n    = expo;
    neg_n     = neg;
    result_n  = result;
    inexact_n = inexact;
    case (state)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          neg_n  = neg_in;
          mag_n  = mag_in;
          expo_n = 11'd1086;
          if (mag_in == 64'd0) begin
            // Zero is always +0 regardless of sign mode.
            result_n  = '0;
            inexact_n = 1'b0;
            state_n   = DONE;
          end else begin
            state_n = NORM;
          end
        end
      end
      NORM: begin
        if (mag[63 -: COARSE] == '0) begin
          mag_n  = mag << COARSE;
          expo_n = expo - 11'(COARSE);
        end else if (!mag[63]) begin
          mag_n  = mag << 1;
          expo_n = expo - 11'd1;
        end else begin
          // A mantissa carry-out leaves the fraction at zero and bumps the exponent.
          result_n  = {neg, expo + {10'd0, mant_sum[52]}, mant_sum[51:0]};
          inexact_n = mag[10] | (|mag[9:0]);
          state_n   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_int_to_double.sv
// Directed and randomized bench for fp_int_to_double with an in-order
// expected-result queue checked whenever an output handshake occurs.
module tb_fp_int_to_double;
  localparam int COARSE = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_int_to_double_if bus();
  logic [1:0] dbg_state;

  fp_int_to_double #(.COARSE(COARSE)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int passed = 0;
  int total  = 0;
  logic [64:0] exp_q[$];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [64:0] ref_conv(input logic [63:0] d, input logic s);
    logic        n;
    logic [63:0] m;
    logic [63:0] norm;
    int          lz;
    logic [10:0] e;
    logic        g;
    logic        st;
    logic [52:0] sum;
    n = s & d[63];
    m = n ? (~d + 64'd1) : d;
    if (m == 64'd0) return '0;
    lz = 0;
    while (!m[63 - lz]) lz++;
    norm = m << lz;
    e    = 11'(1086 - lz);
    g    = norm[10];
    st   = |norm[9:0];
    sum  = {1'b0, norm[62:11]} + {52'd0, g & (st | norm[11])};
    if (sum[52]) e = e + 11'd1;
    return {g | st, n, e, sum[51:0]};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $error("FAIL spurious_output observed=%h expected=none", bus.out_result);
      end else begin
        e = exp_q.pop_front();
        check("result", 72'({bus.out_inexact, bus.out_result}), 72'(e));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  // Returns at 1ns after the accepting edge, i.e. inside cycle 1.
  task automatic send(input logic [63:0] d, input logic s, input bit rnd,
                      input bit do_push, input logic [64:0] expv);
    int n;
    n = 0;
    bus.in_data   = d;
    bus.in_signed = s;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 400) begin
      @(posedge clk); #1;
      if (rnd) bus.out_ready = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      $error("FAIL accept_timeout observed=in_ready_low expected=in_ready_high");
      bus.in_valid = 1'b0;
      return;
    end
    if (do_push) exp_q.push_back(expv);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom};
    if (rnd) bus.out_ready = ($urandom_range(0, 7) != 0);
  endtask

  task automatic wait_out(input int exp_cycle, input string tag);
    int cyc;
    cyc = 1;
    @(negedge clk);
    while (!bus.out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 72'(cyc), 72'(exp_cycle));
    @(posedge clk); #1;
  endtask

  task automatic directed(input logic [63:0] d, input logic s, input logic [63:0] res,
                          input logic inx, input int cyc, input string tag);
    send(d, s, 1'b0, 1'b1, {inx, res});
    wait_out(cyc, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] edge_vals [6];
    logic [63:0] d;
    logic        s;
    int          n;
    edge_vals = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                  64'h0020_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h0060_0000_0000_0800};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 72'({bus.in_ready, bus.out_valid, bus.out_inexact, bus.out_result}), 72'(0));
    check("reset_state", 72'(dbg_state), 72'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 72'(bus.in_ready), 72'(1));
    @(posedge clk); #1;

    // main function and rounding boundaries
    directed(64'h0000_0000_0000_0001, 1'b1, 64'h3FF0_0000_0000_0000, 1'b0, 16, "one");
    directed(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hBFF0_0000_0000_0000, 1'b0, 16, "minus_one");
    directed(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h43F0_0000_0000_0000, 1'b1, 2,  "umax");
    directed(64'h8000_0000_0000_0000, 1'b1, 64'hC3E0_0000_0000_0000, 1'b0, 2,  "int_min");
    directed(64'h0020_0000_0000_0001, 1'b0, 64'h4340_0000_0000_0000, 1'b1, 5,  "tie_even");
    directed(64'h0020_0000_0000_0003, 1'b0, 64'h4340_0000_0000_0002, 1'b1, 5,  "tie_up");
    directed(64'h0020_0000_0000_0002, 1'b0, 64'h4340_0000_0000_0001, 1'b0, 5,  "exact");

    // zero with output back-pressure; a second word waits during DONE
    bus.out_ready = 1'b0;
    send(64'h0, 1'b1, 1'b0, 1'b1, 65'h0);
    wait_out(1, "zero");
    bus.in_data   = 64'h0020_0000_0000_0002;
    bus.in_signed = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_stable", 72'({bus.out_valid, bus.in_ready, bus.out_inexact, bus.out_result}),
            {5'd0, 3'b100, 64'h0});
      @(posedge clk); #1;
    end
    exp_q.push_back({1'b0, 64'h4340_0000_0000_0001});
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("ready_low_in_handshake", 72'(bus.in_ready), 72'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_handshake", 72'(bus.in_ready), 72'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(5, "queued_word");

    // reset during NORM discards the conversion
    send(64'h1, 1'b0, 1'b0, 1'b0, 65'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_reset", 72'({bus.in_ready, bus.out_valid, bus.out_result, dbg_state}), 72'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_mid_reset", 72'(bus.in_ready), 72'(1));
    @(posedge clk); #1;
    directed(64'h2, 1'b0, 64'h4000_0000_0000_0000, 1'b0, 15, "two");

    // random back-to-back traffic with output stalls
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    d = {$urandom, $urandom};
        2:       d = {$urandom, $urandom} >> $urandom_range(0, 63);
        default: d = edge_vals[$urandom_range(0, 5)];
      endcase
      s = 1'($urandom_range(0, 1));
      send(d, s, 1'b1, 1'b1, ref_conv(d, s));
    end
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      n++;
    end
    check("drain_empty", 72'(exp_q.size()), 72'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
